// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator sweep checker.
// The vector count covers every {A,B} pair of two 2-bit operands.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } cmp_state_e;

  localparam int NUM_VECTORS = 16;
  localparam logic [3:0] LAST_IDX = 4'(NUM_VECTORS - 1);

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_rgb_t;

endpackage

// File: rtl/cmp_sweep_checker_if.sv
// Stimulus/response bus between the sweep checker and the comparator under test.
// The checker drives the operands; the comparator drives its three flags.
interface cmp_sweep_checker_if;

  logic a0;
  logic a1;
  logic b0;
  logic b1;
  logic r;
  logic g;
  logic b;

  modport master (
    output a0, a1, b0, b1,
    input  r, g, b
  );

  modport slave (
    input  a0, a1, b0, b1,
    output r, g, b
  );

endinterface

// File: rtl/cmp_expect.sv
// Golden 2-bit unsigned comparator: maps vector index {a1,a0,b1,b0}
// to the expected {A>B, A==B, A<B} flags.
module cmp_expect
  import cmp_pkg::*;
(
  input  logic [3:0] idx,
  output logic [2:0] exp_rgb
);

  logic [1:0] op_a;
  logic [1:0] op_b;
  cmp_rgb_t   rgb;

  always_comb begin
    op_a   = idx[3:2];
    op_b   = idx[1:0];
    rgb.gt = (op_a > op_b);
    rgb.eq = (op_a == op_b);
    rgb.lt = (op_a < op_b);
  end

  assign exp_rgb = rgb;

endmodule

// File: rtl/cmp_sweep_checker.sv
// Walks all 16 operand pairs into an external 2-bit comparator, waits for it
// to settle, and tallies responses that disagree with the golden model.
module cmp_sweep_checker
  import cmp_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a0,
  output logic       a1,
  output logic       b0,
  output logic       b1,
  input  logic       r,
  input  logic       g,
  input  logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_err_idx,
  output logic       err_seen
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  cmp_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] settle_q, settle_d;
  logic [4:0] err_count_q, err_count_d;
  logic [3:0] first_err_idx_q, first_err_idx_d;
  logic       err_seen_q, err_seen_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic [2:0] exp_rgb;
  logic       mismatch;

  cmp_expect u_expect (
    .idx     (idx_q),
    .exp_rgb (exp_rgb)
  );

  // Any response other than the single expected one-hot code is an error,
  // which also catches 000 and multi-hot responses.
  assign mismatch = ({r, g, b} != exp_rgb);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    settle_d        = settle_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    err_seen_d      = err_seen_q;
    busy_d          = busy_q;
    done_d          = done_q;
    pass_d          = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d         = ST_SETTLE;
          idx_d           = '0;
          settle_d        = '0;
          err_count_d     = '0;
          first_err_idx_d = '0;
          err_seen_d      = 1'b0;
          busy_d          = 1'b1;
          done_d          = 1'b0;
          pass_d          = 1'b0;
        end
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          err_count_d = err_count_q + 5'd1;
          if (!err_seen_q) begin
            first_err_idx_d = idx_q;
            err_seen_d      = 1'b1;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == 5'd0);
        end else begin
          state_d = ST_SETTLE;
          idx_d   = idx_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      settle_q        <= '0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      err_seen_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      settle_q        <= settle_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      err_seen_q      <= err_seen_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  assign {a1, a0}      = idx_q[3:2];
  assign {b1, b0}      = idx_q[1:0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign err_seen      = err_seen_q;

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Scoreboard bench: two checkers (settle 4 and settle 1) driving behavioural
// comparators with selectable faults; results checked when done rises.
module tb_cmp_sweep_checker;

  typedef struct {
    int         done_cyc;
    logic [4:0] ec;
    logic [3:0] fei;
    logic       es;
    logic       ps;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   mode = 0;
  logic [2:0] fault_tab [16];

  exp_t q0[$];
  exp_t q1[$];

  logic       busy0, done0, pass0, es0;
  logic [4:0] ec0;
  logic [3:0] fei0;
  logic       busy1, done1, pass1, es1;
  logic [4:0] ec1;
  logic [3:0] fei1;
  logic       done0_prev = 1'b0;
  logic       done1_prev = 1'b0;

  cmp_sweep_checker_if bus0 ();
  cmp_sweep_checker_if bus1 ();

  cmp_sweep_checker #(.SETTLE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .a0(bus0.a0), .a1(bus0.a1), .b0(bus0.b0), .b1(bus0.b1),
    .r(bus0.r), .g(bus0.g), .b(bus0.b),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
    .first_err_idx(fei0), .err_seen(es0)
  );

  cmp_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a0(bus1.a0), .a1(bus1.a1), .b0(bus1.b0), .b1(bus1.b1),
    .r(bus1.r), .g(bus1.g), .b(bus1.b),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .first_err_idx(fei1), .err_seen(es1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] ideal_rgb(input int v);
    int a, bb;
    a  = v / 4;
    bb = v % 4;
    return {a > bb, a == bb, a < bb};
  endfunction

  function automatic logic [2:0] model_rgb(input int m, input int v);
    logic [2:0] e;
    e = ideal_rgb(v);
    case (m)
      1:       return e & 3'b101;
      2:       return {e[0], e[1], e[2]};
      3:       return fault_tab[v];
      default: return e;
    endcase
  endfunction

  // Behavioural comparators under test
  always_comb begin
    {bus0.r, bus0.g, bus0.b} = model_rgb(mode, int'({bus0.a1, bus0.a0, bus0.b1, bus0.b0}));
    {bus1.r, bus1.g, bus1.b} = model_rgb(mode, int'({bus1.a1, bus1.a0, bus1.b1, bus1.b0}));
  end

  function automatic exp_t predict(input int settle, input int acc);
    exp_t e;
    int   n;
    n       = 0;
    e.fei   = '0;
    e.es    = 1'b0;
    for (int v = 0; v < 16; v++) begin
      if (model_rgb(mode, v) != ideal_rgb(v)) begin
        if (n == 0) begin
          e.fei = 4'(v);
          e.es  = 1'b1;
        end
        n++;
      end
    end
    e.ec       = 5'(n);
    e.ps       = (n == 0);
    e.done_cyc = acc + 16 * (settle + 1);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per rising edge of done
  always @(negedge clk) begin
    exp_t e;
    if (done0 && !done0_prev) begin
      if (q0.size() == 0) check("done0_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        check("done0_cycle", cyc, e.done_cyc);
        check("err_count0", int'(ec0), int'(e.ec));
        check("first_err_idx0", int'(fei0), int'(e.fei));
        check("err_seen0", int'(es0), int'(e.es));
        check("pass0", int'(pass0), int'(e.ps));
      end
    end
    done0_prev <= done0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1 && !done1_prev) begin
      if (q1.size() == 0) check("done1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        check("done1_cycle", cyc, e.done_cyc);
        check("err_count1", int'(ec1), int'(e.ec));
        check("first_err_idx1", int'(fei1), int'(e.fei));
        check("err_seen1", int'(es1), int'(e.es));
        check("pass1", int'(pass1), int'(e.ps));
      end
    end
    done1_prev <= done1;
  end

  task automatic pulse(input int which, output int acc);
    @(negedge clk);
    if (which == 0) start0 = 1'b1;
    else            start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_empty(input int which, input int limit);
    int n;
    n = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (which == 0) begin
      check("done0_timeout", q0.size(), 0);
      q0.delete();
    end else begin
      check("done1_timeout", q1.size(), 0);
      q1.delete();
    end
  endtask

  task automatic check_zero0(input string tag);
    check({tag, "_bus"}, int'({bus0.a1, bus0.a0, bus0.b1, bus0.b0}), 0);
    check({tag, "_busy"}, int'(busy0), 0);
    check({tag, "_done"}, int'(done0), 0);
    check({tag, "_pass"}, int'(pass0), 0);
    check({tag, "_err_count"}, int'(ec0), 0);
    check({tag, "_first_err_idx"}, int'(fei0), 0);
    check({tag, "_err_seen"}, int'(es0), 0);
  endtask

  task automatic sweep0(input int m, input int limit);
    int acc;
    mode = m;
    pulse(0, acc);
    q0.push_back(predict(4, acc));
    wait_empty(0, limit);
  endtask

  initial begin
    int acc;
    int acc2;
    for (int v = 0; v < 16; v++) fault_tab[v] = ideal_rgb(v);

    repeat (3) @(posedge clk);
    #1;
    check_zero0("reset0");
    check("reset1_busy", int'(busy1), 0);
    check("reset1_done", int'(done1), 0);
    check("reset1_err_count", int'(ec1), 0);
    @(negedge clk);
    rst = 1'b0;

    // Ideal comparator with per-cycle operand/busy tracking
    mode = 0;
    pulse(0, acc);
    q0.push_back(predict(4, acc));
    for (int t = 0; t <= 80; t++) begin
      check("vector0", int'({bus0.a1, bus0.a0, bus0.b1, bus0.b0}), (t / 5 > 15) ? 15 : t / 5);
      check("busy0", int'(busy0), (t < 80) ? 1 : 0);
      if (t < 80) begin
        @(posedge clk);
        #1;
      end
    end
    wait_empty(0, 20);

    sweep0(1, 120);
    sweep0(2, 120);

    // Reset in the middle of a sweep discards everything
    mode = 2;
    pulse(0, acc);
    repeat (36) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero0("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    sweep0(0, 120);

    // A start pulse during a sweep is ignored
    mode = 0;
    pulse(0, acc);
    q0.push_back(predict(4, acc));
    repeat (19) @(posedge clk);
    pulse(0, acc2);
    check("ignored_start_cycle", acc2 - acc, 20);
    check("ignored_start_busy", int'(busy0), 1);
    wait_empty(0, 120);

    // Randomised fault tables
    for (int k = 0; k < 6; k++) begin
      for (int v = 0; v < 16; v++)
        fault_tab[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : ideal_rgb(v);
      if (k % 2 == 0) begin
        sweep0(3, 120);
      end else begin
        mode = 3;
        pulse(1, acc);
        q1.push_back(predict(1, acc));
        wait_empty(1, 60);
      end
    end

    // Short settle: restart while done is high
    mode = 1;
    pulse(1, acc);
    q1.push_back(predict(1, acc));
    wait_empty(1, 60);
    check("restart_pre_done", int'(done1), 1);
    check("restart_pre_err_count", int'(ec1), 4);
    mode = 0;
    pulse(1, acc2);
    q1.push_back(predict(1, acc2));
    check("restart_done_drop", int'(done1), 0);
    check("restart_busy", int'(busy1), 1);
    check("restart_err_count", int'(ec1), 0);
    check("restart_err_seen", int'(es1), 0);
    check("restart_first_err_idx", int'(fei1), 0);
    wait_empty(1, 60);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
